ps02_result_fifo: RTL and testbench

//   Downstream stage of the ALU result path: buffers each {flag, R} pair from
//   the ALU into a small synchronous FIFO. Presents the pairs to a consumer
//   (display/UART/checker) with a valid/ready handshake.

---
 rtl/ps02_result_fifo_if.sv | 13 +
 rtl/ps02_result_fifo.sv | 56 +++++
 tb/tb_ps02_result_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ps02_result_fifo_if.sv
// ps02_result_fifo_if: ALU-side and consumer-side valid/ready handshake bundle for the result FIFO
interface ps02_result_fifo_if #(parameter int data_width = 32);
  logic                         in_valid;
  logic signed [data_width-1:0] R;
  logic                         flag;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [data_width-1:0] out_R;
  logic                         out_flag;
  modport master (output in_valid, R, flag, out_ready, input in_ready, out_valid, out_R, out_flag);
  modport slave (input in_valid, R, flag, out_ready, output in_ready, out_valid, out_R, out_flag);
endinterface

// File: rtl/ps02_result_fifo.sv
// ps02_result_fifo: show-ahead {flag,R} FIFO with sticky drop flag; RESULT_FIFO_FLAG_CNT_EN adds a saturating flag=1 push counter
module ps02_result_fifo #(
  parameter int data_width = 32,
  parameter int depth_log2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  ps02_result_fifo_if.slave     bus,
  output logic [depth_log2:0]   count,
  output logic                  overflow
`ifdef RESULT_FIFO_FLAG_CNT_EN
  ,
  output logic [15:0]           flag_cnt
`endif
);
  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] full_cnt = {1'b1, {depth_log2{1'b0}}};
  logic [data_width:0]   mem [depth];
  logic [depth_log2-1:0] wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  logic [data_width:0]   head;
  // handshake decoded from registered count only; head masked while empty
  always_comb begin
    full          = count == full_cnt;
    empty         = count == '0;
    bus.in_ready  = !full;
    bus.out_valid = !empty;
    push          = bus.in_valid & !full;
    pop           = !empty & bus.out_ready;
    head          = mem[rd_ptr];
    bus.out_R     = empty ? '0 : head[data_width-1:0];
    bus.out_flag  = empty ? 1'b0 : head[data_width];
  end
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.flag, bus.R};
  // pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= push & !pop ? count + 1'b1 : !push & pop ? count - 1'b1 : count;
      overflow <= overflow | (bus.in_valid & full);
    end
`ifdef RESULT_FIFO_FLAG_CNT_EN
  // saturating count of accepted pushes carrying flag=1
  always_ff @(posedge clk or posedge rst)
    if (rst) flag_cnt <= '0;
    else if (push & bus.flag & (flag_cnt != 16'hFFFF)) flag_cnt <= flag_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_ps02_result_fifo.sv
// tb_ps02_result_fifo: scoreboard bench for ps02_result_fifo (flag counter checked when RESULT_FIFO_FLAG_CNT_EN is defined)
module tb_ps02_result_fifo;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] count;
  logic overflow;
  int vectors = 0;
  int errs = 0;
  logic [32:0] q [$];
  logic ovf_m = 0;
  ps02_result_fifo_if #(32) bus ();
`ifdef RESULT_FIFO_FLAG_CNT_EN
  logic [15:0] flag_cnt;
  logic [15:0] fc_m = 0;
`endif
  ps02_result_fifo #(.data_width(32), .depth_log2(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .count(count),
    .overflow(overflow)
`ifdef RESULT_FIFO_FLAG_CNT_EN
    ,
    .flag_cnt(flag_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // scoreboard: inputs change only just after posedge, so negedge sees what the next edge will act on
  always @(negedge clk) begin
    logic full;
    if (rst) begin
      q.delete();
      ovf_m = 0;
`ifdef RESULT_FIFO_FLAG_CNT_EN
      fc_m = 0;
`endif
    end else begin
      full = q.size() == 8;
      chk("count", 32'(count), q.size());
      chk("in_ready", 32'(bus.in_ready), 32'(!full));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("overflow", 32'(overflow), 32'(ovf_m));
`ifdef RESULT_FIFO_FLAG_CNT_EN
      chk("flag_cnt", 32'(flag_cnt), 32'(fc_m));
`endif
      if (q.size() == 0) begin
        chk("mask_R", bus.out_R, 0);
        chk("mask_flag", 32'(bus.out_flag), 0);
      end else begin
        chk("head_R", bus.out_R, q[0][31:0]);
        chk("head_flag", 32'(bus.out_flag), 32'(q[0][32]));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid) begin
        if (full) ovf_m = 1;
        else begin
          q.push_back({bus.flag, bus.R});
`ifdef RESULT_FIFO_FLAG_CNT_EN
          if (bus.flag && fc_m != 16'hFFFF) fc_m++;
`endif
        end
      end
    end
  end
  task automatic cyc(input logic v, input logic [31:0] r, input logic f, input logic ordy);
    bus.in_valid  = v;
    bus.R         = r;
    bus.flag      = f;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 0;
    cyc(0, 0, 0, 0);
  endtask
  initial begin
    bus.in_valid = 0; bus.R = 0; bus.flag = 0; bus.out_ready = 0;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 32'(50 + i), 1'(i), 0);
    cyc(0, 0, 0, 0);
    rst = 1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 0;
    cyc(0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_R", bus.out_R, 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    cyc(1, -32'sd5, 1, 0);
    cyc(1, 7, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t2_count", 32'(count), 2);
    chk("t2_R", bus.out_R, 32'hFFFFFFFB);
    chk("t2_flag", 32'(bus.out_flag), 1);
    cyc(0, 0, 0, 1);
    chk("t2_R2", bus.out_R, 7);
    chk("t2_flag2", 32'(bus.out_flag), 0);
    cyc(0, 0, 0, 1);
    chk("t2_empty", 32'(bus.out_valid), 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 32'(i), 0, 0);
      if (i == 8) chk("t3_in_ready", 32'(bus.in_ready), 0);
    end
    cyc(0, 0, 0, 0);
    chk("t3_count", 32'(count), 8);
    chk("t3_overflow", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain", bus.out_R, 32'(i));
      cyc(0, 0, 0, 1);
    end
    chk("t3_empty", 32'(count), 0);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 32'(100 + i), 0, 0);
    chk("t4_ovf_before", 32'(overflow), 0);
    cyc(1, 999, 1, 1);
    cyc(0, 0, 0, 0);
    chk("t4_count", 32'(count), 7);
    chk("t4_head", bus.out_R, 101);
    chk("t4_overflow", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'(200 + i), 1'(i), 0);
    for (int i = 3; i < 23; i++) begin
      cyc(1, 32'(200 + i), 1'(i), 1);
      chk("t5_count", 32'(count), 3);
    end
    chk("t5_head", bus.out_R, 220);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
`ifdef RESULT_FIFO_FLAG_CNT_EN
    do_reset();
    begin
      logic [5:0] fl;
      fl = 6'b101101;
      for (int i = 0; i < 6; i++) cyc(1, 32'(300 + i), fl[5 - i], 0);
    end
    cyc(0, 0, 0, 0);
    chk("t6_flag_cnt", 32'(flag_cnt), 4);
    cyc(1, 310, 0, 0);
    cyc(1, 311, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'(320 + i), 1, 0);
    cyc(0, 0, 0, 0);
    chk("t6_flag_cnt_full", 32'(flag_cnt), 4);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
`endif
    cyc(0, 0, 0, 0);
    chk("final_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
